// File: rtl/arith_arb_pkg.sv
// Shared constants for the two-requester add/sub arbiter: FSM states, op codes,
// requester ids and the signed-overflow helper.
package arith_arb_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam logic REQ0   = 1'b0;
    localparam logic REQ1   = 1'b1;

    localparam int ARITH_W = 32;

    // Signed overflow from operand and result sign bits; sub compares a against -b.
    function automatic logic calc_ovf(
        input logic op_sub,
        input logic a_msb,
        input logic b_msb,
        input logic z_msb
    );
        logic result;
        if (op_sub == OP_SUB) begin
            result = (a_msb != b_msb) && (z_msb != a_msb);
        end else begin
            result = (a_msb == b_msb) && (z_msb != a_msb);
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way grant picker: a lone request always wins; on contention either
// alternate away from last_gnt or give requester 0 fixed priority.
module rr_pick2
    import arith_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    input  logic rr_en,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            if (rr_en) begin
                gnt0 = (last_gnt == REQ1);
                gnt1 = (last_gnt == REQ0);
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule

// File: rtl/yArith.sv
// Fixed 32-bit adder/subtractor: ctrl=0 computes a+b, ctrl=1 computes a-b as a+~b+1.
module yArith (
    output logic [31:0] z,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ctrl
);

    logic [31:0] b_eff;
    logic [32:0] sum;

    always_comb begin
        b_eff = ctrl ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {32'd0, ctrl};
    end

    assign z    = sum[31:0];
    assign cout = sum[32];

endmodule

// File: rtl/arith_share_arbiter.sv
// Shares one yArith add/sub datapath between two requesters: picks a winner in
// IDLE, captures its operands, evaluates in EXEC and returns a registered result.
module arith_share_arbiter
    import arith_arb_pkg::*;
#(
    parameter int W     = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         sub0,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic         req1,
    input  logic         sub1,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] z,
    output logic         cout,
    output logic         ovf,
    output logic         busy
);

    state_t         state_reg;
    logic           last_gnt_reg;
    logic           owner_reg;
    logic [W-1:0]   op_a_reg;
    logic [W-1:0]   op_b_reg;
    logic           op_sub_reg;
    logic [W-1:0]   z_reg;
    logic           cout_reg;
    logic           ovf_reg;
    logic [1:0]     done_reg;

    logic [W-1:0]   a_vec   [2];
    logic [W-1:0]   b_vec   [2];
    logic [1:0]     sub_vec;
    logic [1:0]     pick_vec;
    logic [1:0]     gnt_vec;
    logic           winner;
    logic           any_gnt;

    logic [W-1:0]   sum;
    logic           carry;

    // Gather the per-requester ports into indexable arrays so capture is a plain mux.
    assign a_vec[0]   = a0;
    assign a_vec[1]   = a1;
    assign b_vec[0]   = b0;
    assign b_vec[1]   = b1;
    assign sub_vec[0] = sub0;
    assign sub_vec[1] = sub1;

    rr_pick2 u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_reg),
        .rr_en    (RR_EN),
        .gnt0     (pick_vec[0]),
        .gnt1     (pick_vec[1])
    );

    // Grants only exist in IDLE and are forced low while reset is asserted.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt_vec[gi] = rst_n && (state_reg == S_IDLE) && pick_vec[gi];
        end
    endgenerate

    assign any_gnt = gnt_vec[0] | gnt_vec[1];
    assign winner  = gnt_vec[1] ? REQ1 : REQ0;

    yArith u_arith (
        .z    (sum),
        .cout (carry),
        .a    (op_a_reg),
        .b    (op_b_reg),
        .ctrl (op_sub_reg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            last_gnt_reg <= REQ1;
            owner_reg    <= REQ0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_sub_reg   <= OP_ADD;
            z_reg        <= '0;
            cout_reg     <= 1'b0;
            ovf_reg      <= 1'b0;
            done_reg     <= 2'b00;
        end else begin
            done_reg <= 2'b00;
            case (state_reg)
                S_IDLE: begin
                    if (any_gnt) begin
                        op_a_reg     <= a_vec[winner];
                        op_b_reg     <= b_vec[winner];
                        op_sub_reg   <= sub_vec[winner];
                        owner_reg    <= winner;
                        last_gnt_reg <= winner;
                        state_reg    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    z_reg     <= sum;
                    cout_reg  <= carry;
                    ovf_reg   <= calc_ovf(op_sub_reg, op_a_reg[W-1], op_b_reg[W-1], sum[W-1]);
                    done_reg  <= (owner_reg == REQ1) ? 2'b10 : 2'b01;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign gnt0  = gnt_vec[0];
    assign gnt1  = gnt_vec[1];
    assign done0 = done_reg[0];
    assign done1 = done_reg[1];
    assign z     = z_reg;
    assign cout  = cout_reg;
    assign ovf   = ovf_reg;
    assign busy  = (state_reg == S_EXEC);

endmodule

// File: tb/tb_arith_share_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share one stimulus stream.
module tb_arith_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, sub0, req1, sub1;
    logic [31:0] a0, b0, a1, b1;

    logic        rr_gnt0, rr_gnt1, rr_done0, rr_done1, rr_cout, rr_ovf, rr_busy;
    logic [31:0] rr_z;
    logic        fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_cout, fp_ovf, fp_busy;
    logic [31:0] fp_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arith_share_arbiter #(.W(32), .RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .sub0(sub0), .a0(a0), .b0(b0),
        .req1(req1), .sub1(sub1), .a1(a1), .b1(b1),
        .gnt0(rr_gnt0), .gnt1(rr_gnt1), .done0(rr_done0), .done1(rr_done1),
        .z(rr_z), .cout(rr_cout), .ovf(rr_ovf), .busy(rr_busy)
    );

    arith_share_arbiter #(.W(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .sub0(sub0), .a0(a0), .b0(b0),
        .req1(req1), .sub1(sub1), .a1(a1), .b1(b1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1),
        .z(fp_z), .cout(fp_cout), .ovf(fp_ovf), .busy(fp_busy)
    );

    typedef struct {
        logic        who;
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; sub0 = 1'b0; a0 = '0; b0 = '0;
        req1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    // Single-requester op: gnt in N, busy in N+1, done/result in N+2, done gone in N+3.
    task automatic do_op(input vec_t v, input string tag);
        if (v.who == 1'b0) begin
            req0 = 1'b1; sub0 = v.sub; a0 = v.a; b0 = v.b;
        end else begin
            req1 = 1'b1; sub1 = v.sub; a1 = v.a; b1 = v.b;
        end
        #1;
        chk({tag, " rr gnt0"}, 32'(rr_gnt0), 32'(v.who == 1'b0));
        chk({tag, " rr gnt1"}, 32'(rr_gnt1), 32'(v.who == 1'b1));
        chk({tag, " fp gnt"},  32'(v.who ? fp_gnt1 : fp_gnt0), 32'd1);
        next_cycle();
        req0 = 1'b0; req1 = 1'b0;
        // Scramble operands after capture; the captured copies must be used.
        a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678; a1 = 32'hCAFE_F00D; b1 = 32'h0BAD_0BAD;
        sub0 = ~v.sub; sub1 = ~v.sub;
        #1;
        chk({tag, " busy"},  32'(rr_busy), 32'd1);
        chk({tag, " no gnt exec"}, 32'({rr_gnt0, rr_gnt1}), 32'd0);
        chk({tag, " early done"}, 32'({rr_done1, rr_done0}), 32'd0);
        next_cycle();
        chk({tag, " done0"}, 32'(rr_done0), 32'(v.who == 1'b0));
        chk({tag, " done1"}, 32'(rr_done1), 32'(v.who == 1'b1));
        chk({tag, " z"},     rr_z, v.z);
        chk({tag, " cout"},  32'(rr_cout), 32'(v.cout));
        chk({tag, " ovf"},   32'(rr_ovf), 32'(v.ovf));
        chk({tag, " fp z"},  fp_z, v.z);
        $display("op %s who=%0d sub=%0d a=%h b=%h -> z=%h cout=%0d ovf=%0d", tag, v.who, v.sub,
                 v.a, v.b, rr_z, rr_cout, rr_ovf);
        next_cycle();
        chk({tag, " done pulse width"}, 32'({rr_done1, rr_done0}), 32'd0);
        chk({tag, " z held"}, rr_z, v.z);
        idle_inputs();
    endtask

    // Expected per-cycle behaviour while both requesters hold req for 6 cycles.
    logic [1:0]  exp_rr_gnt  [7];
    logic [1:0]  exp_rr_done [7];
    logic [1:0]  exp_fp_gnt  [7];
    logic [1:0]  exp_fp_done [7];
    logic [31:0] exp_rr_z    [7];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 32'd5,          32'd3,          32'd2,          1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 32'd0,          32'd0,          32'd0,          1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 32'h1234_5678,  32'h1111_1111,  32'h2345_6789,  1'b0, 1'b0};

        // Contention: a0+b0 = 10+1 = 11 (add), a1-b1 = 20-2 = 18 (sub).
        exp_rr_gnt  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        exp_rr_done = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        exp_fp_gnt  = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00};
        exp_fp_done = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
        exp_rr_z    = '{32'd0, 32'd0, 32'd11, 32'd11, 32'd18, 32'd18, 32'd11};

        idle_inputs();
        rst_n = 1'b0;
        req0  = 1'b1;
        #1;
        chk("gnt0 in reset", 32'(rr_gnt0), 32'd0);
        next_cycle();
        next_cycle();
        chk("gnt in reset fp", 32'({fp_gnt1, fp_gnt0}), 32'd0);
        rst_n = 1'b1;
        req0  = 1'b0;
        #1;
        chk("reset z",    rr_z, 32'd0);
        chk("reset cout", 32'(rr_cout), 32'd0);
        chk("reset ovf",  32'(rr_ovf), 32'd0);
        chk("reset done", 32'({rr_done1, rr_done0}), 32'd0);
        chk("reset gnt",  32'({rr_gnt1, rr_gnt0}), 32'd0);
        chk("reset busy", 32'(rr_busy), 32'd0);
        next_cycle();
        chk("idle no req stays", 32'(rr_busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i], $sformatf("v%0d", i));
        end

        // Contention from a fresh reset so requester 0 wins first.
        do_reset();
        req0 = 1'b1; sub0 = 1'b0; a0 = 32'd10; b0 = 32'd1;
        req1 = 1'b1; sub1 = 1'b1; a1 = 32'd20; b1 = 32'd2;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            #1;
            chk($sformatf("cont c%0d rr gnt", c),  32'({rr_gnt1, rr_gnt0}),   32'(exp_rr_gnt[c]));
            chk($sformatf("cont c%0d rr done", c), 32'({rr_done1, rr_done0}), 32'(exp_rr_done[c]));
            chk($sformatf("cont c%0d fp gnt", c),  32'({fp_gnt1, fp_gnt0}),   32'(exp_fp_gnt[c]));
            chk($sformatf("cont c%0d fp done", c), 32'({fp_done1, fp_done0}), 32'(exp_fp_done[c]));
            chk($sformatf("cont c%0d rr z", c),    rr_z, exp_rr_z[c]);
            $display("cont c%0d rr gnt=%b done=%b z=%0d fp gnt=%b done=%b", c,
                     {rr_gnt1, rr_gnt0}, {rr_done1, rr_done0}, rr_z,
                     {fp_gnt1, fp_gnt0}, {fp_done1, fp_done0});
            next_cycle();
        end
        idle_inputs();

        // Reset during EXEC discards the op.
        do_reset();
        req0 = 1'b1; a0 = 32'd5; b0 = 32'd7; sub0 = 1'b0;
        #1;
        chk("rexec gnt0", 32'(rr_gnt0), 32'd1);
        next_cycle();
        req0 = 1'b0;
        chk("rexec busy", 32'(rr_busy), 32'd1);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        #1;
        chk("rexec no done", 32'({rr_done1, rr_done0}), 32'd0);
        chk("rexec z",       rr_z, 32'd0);
        chk("rexec busy off", 32'(rr_busy), 32'd0);
        next_cycle();
        chk("rexec still no done", 32'({rr_done1, rr_done0}), 32'd0);
        $display("reset-in-exec z=%h done=%b", rr_z, {rr_done1, rr_done0});
        do_op(vecs[0], "after-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
